// File: rtl/bti_ifetch.sv
// Sequential BTI instruction fetch: credit-limited prefetch into a small tagged FIFO, redirect flush with stale-response dropping.
// Optional build macro BTI_IFETCH_ERR_HALT_EN: a buffered bus-error word stops further issue until redirect/reset.
module bti_ifetch #(
    parameter int                BTI_AW = 32,
    parameter int                BTI_DW = 32,
    parameter int                TIDW   = 4,
    parameter int                DEPTH  = 4,
    parameter logic [BTI_AW-1:0] RST_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redir_vld,
    input  logic [BTI_AW-1:0] redir_pc,
    output logic              bti_req_vld,
    input  logic              bti_req_rdy,
    output logic [BTI_AW-1:0] bti_req_addr,
    output logic [TIDW-1:0]   bti_req_tid,
    input  logic              bti_rsp_vld,
    output logic              bti_rsp_rdy,
    input  logic [BTI_DW-1:0] bti_rsp_data,
    input  logic [TIDW-1:0]   bti_rsp_tid,
    input  logic              bti_rsp_ok,
    output logic              inst_vld,
    input  logic              inst_rdy,
    output logic [BTI_DW-1:0] inst_data,
    output logic [BTI_AW-1:0] inst_pc,
    output logic              inst_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [BTI_AW-1:0] r_req_pc;
    logic [BTI_AW-1:0] r_rsp_pc;
    logic [CW-1:0]     r_inflight;
    logic [CW-1:0]     r_drop_cnt;
    logic [CW-1:0]     r_cnt;
    logic [TIDW-1:0]   r_tid;
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [BTI_DW-1:0] r_mem_data [DEPTH];
    logic [BTI_AW-1:0] r_mem_pc   [DEPTH];
    logic [DEPTH-1:0]  r_mem_err;

    logic [CW:0]       w_credit_sum;
    logic              w_halted;
    logic              w_req_vld;
    logic              w_req_fire;
    logic              w_rsp_fire;
    logic              w_drop;
    logic              w_push;
    logic              w_inst_vld;
    logic              w_pop;
    logic [BTI_AW-1:0] w_redir_pc;
    logic              w_unused;

    // Buffered words plus outstanding requests never exceed DEPTH, so a response always has room.
    assign w_credit_sum = {1'b0, r_inflight} + {1'b0, r_cnt};
    assign w_req_vld    = !rst && !redir_vld && !w_halted && (w_credit_sum < (CW+1)'(DEPTH));
    assign w_req_fire   = w_req_vld && bti_req_rdy;
    assign w_rsp_fire   = bti_rsp_vld && !rst;
    assign w_drop       = (r_drop_cnt != '0) || redir_vld;
    assign w_push       = w_rsp_fire && !w_drop;
    assign w_inst_vld   = !rst && (r_cnt != '0) && !redir_vld;
    assign w_pop        = w_inst_vld && inst_rdy;
    assign w_redir_pc   = {redir_pc[BTI_AW-1:2], 2'b00};
    assign w_unused     = ^{bti_rsp_tid, redir_pc[1:0]};

    assign bti_req_vld  = w_req_vld;
    assign bti_req_addr = r_req_pc;
    assign bti_req_tid  = r_tid;
    assign bti_rsp_rdy  = 1'b1;
    assign inst_vld     = w_inst_vld;
    assign inst_data    = r_mem_data[r_rptr];
    assign inst_pc      = r_mem_pc[r_rptr];
    assign inst_err     = r_mem_err[r_rptr];

    // Redirect recomputes drop_cnt from inflight so back-to-back redirects need no accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_pc   <= RST_PC;
            r_rsp_pc   <= RST_PC;
            r_inflight <= '0;
            r_drop_cnt <= '0;
            r_tid      <= '0;
        end else if (redir_vld) begin
            r_req_pc   <= w_redir_pc;
            r_rsp_pc   <= w_redir_pc;
            r_inflight <= r_inflight - CW'(w_rsp_fire);
            r_drop_cnt <= r_inflight - CW'(w_rsp_fire);
        end else begin
            if (w_req_fire) begin
                r_req_pc <= r_req_pc + BTI_AW'(4);
                r_tid    <= r_tid + TIDW'(1);
            end
            if (w_rsp_fire && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - CW'(1);
            end
            if (w_push) begin
                r_rsp_pc <= r_rsp_pc + BTI_AW'(4);
            end
            r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_rsp_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redir_vld) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wptr] <= bti_rsp_data;
            r_mem_pc[r_wptr]   <= r_rsp_pc;
            r_mem_err[r_wptr]  <= !bti_rsp_ok;
        end
    end

`ifdef BTI_IFETCH_ERR_HALT_EN
    logic r_halted;

    always_ff @(posedge clk) begin
        if (rst || redir_vld) begin
            r_halted <= 1'b0;
        end else if (w_push && !bti_rsp_ok) begin
            r_halted <= 1'b1;
        end
    end

    assign w_halted = r_halted;
`else
    assign w_halted = 1'b0;
`endif

endmodule
